wb_intercon_ns: RTL and testbench
=================================

WB_INTERCON_NS -- requirements
Module: wb_intercon_ns

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of Wishbone slave ports (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, address bus width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, data bus width.
REQ-004 SHALL have parameter SLAVE_BASE, default {16'h00C0,16'h0080,16'h0040,16'h0000}, packed NUM_SLAVES*ADDR_WIDTH base addresses; slice i belongs to slave i.
REQ-005 SHALL have parameter SLAVE_MASK, default {4{16'hFFC0}}, packed NUM_SLAVES*ADDR_WIDTH decode masks.
REQ-006 SHALL have parameter TIMEOUT, default 16, maximum cycles spent waiting for a slave ack (1..255).
REQ-007 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- wbm_address  in  ADDR_WIDTH  master address
- wbm_writedata  in  DATA_WIDTH  master write data
- wbm_readdata  out  DATA_WIDTH  registered read data to master
- wbm_write  in  1  1 = write
- wbm_cycle  in  1  master bus cycle
- wbm_strobe  in  1  master strobe
- wbm_ack  out  1  registered ack, one-cycle pulse
- wbm_err  out  1  registered error (unmapped or timeout), one-cycle pulse
- wbi_address  out  ADDR_WIDTH  broadcast address
- wbi_writedata  out  DATA_WIDTH  broadcast write data
- wbi_write  out  1  broadcast write enable
- wbi_readdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data, slice i = slave i
- wbi_cycle  out  NUM_SLAVES  per-slave cycle
- wbi_strobe  out  NUM_SLAVES  per-slave strobe
- wbi_ack  in  NUM_SLAVES  per-slave ack
REQ-008 Clock and reset SHALL be: one clock; reset is synchronous and active-high.

Function
REQ-009 Slave i SHALL be hit when (wbm_address & MASK_i) == (BASE_i & MASK_i); on overlapping hits the lowest index SHALL win.
REQ-010 wbi_address, wbi_writedata, wbi_write SHALL be combinational copies of the master signals.
REQ-011 FSM states SHALL be IDLE, ACTIVE, RESP, ERR.
REQ-012 IDLE: on wbm_cycle&wbm_strobe with a hit, SHALL latch sel = hit index, clear timeout counter, go ACTIVE; with no hit SHALL go ERR.
REQ-013 ACTIVE: wbi_cycle[sel]=wbm_cycle and wbi_strobe[sel]=wbm_strobe, all other bits 0; wbi_cycle/wbi_strobe SHALL be 0 in every other state.
REQ-014 ACTIVE with wbi_ack[sel]=1: SHALL register wbi_readdata slice sel into wbm_readdata (reads and writes alike) and go RESP; acks on non-selected slaves SHALL be ignored.
REQ-015 ACTIVE, no ack, counter == TIMEOUT-1: SHALL go ERR; otherwise counter increments.
REQ-016 ACTIVE with wbm_cycle=0 (master abort): SHALL return to IDLE next cycle, no ack, no err.
REQ-017 RESP: wbm_ack=1 for exactly one cycle, then IDLE. ERR: wbm_err=1 for exactly one cycle, then IDLE.
REQ-018 wbm_ack and wbm_err SHALL never be asserted together.
REQ-019 Minimum latency: master strobe seen in cycle 0, slave strobe in cycle 1, combinational slave ack in cycle 1 gives wbm_ack in cycle 2; unmapped access gives wbm_err in cycle 1.
REQ-020 wbm_readdata SHALL hold its value between acks.
REQ-021 Timeout counter SHALL be $clog2(TIMEOUT+1) bits, never wrap.

Reset
REQ-022 While reset=1 at a clk edge: state IDLE, wbm_ack=0, wbm_err=0, wbm_readdata=0, counter=0, sel=0, wbi_cycle=0, wbi_strobe=0 from next cycle.
REQ-023 Reset during ACTIVE or RESP SHALL drop all slave strobes and suppress the pending ack/err.

Verification
REQ-024 Read 0x0045, slave 1 acks in first ACTIVE cycle with 16'hBEEF -> wbi_strobe=4'b0010 in cycle 1, wbm_ack and wbm_readdata=16'hBEEF in cycle 2.
REQ-025 Write 0x00C3 data 16'h1234, slave 3 acks after 3 wait cycles -> wbi_writedata=16'h1234, wbi_strobe=4'b1000 for 4 cycles, single wbm_ack.
REQ-026 Access 0x0100 (no hit) -> no wbi_strobe bit set, wbm_err=1 in cycle 1 only.
REQ-027 Access 0x0000, slave 0 never acks -> wbi_strobe[0] high 16 cycles, then wbm_err one cycle, strobe low.
REQ-028 Slave 2 access, wbm_cycle dropped in cycle 2 -> IDLE in cycle 3, no wbm_ack/wbm_err; reset asserted mid-ACTIVE -> all outputs at reset values next cycle.
REQ-029 Spurious wbi_ack[3] while slave 1 selected -> ignored, wbm_ack only after wbi_ack[1].

Source files
------------

// File: rtl/wb_intercon_ns.sv
// Single-master Wishbone interconnect with address decode, per-slave cycle/strobe
// steering, registered ack/err/readdata back to the master and an ack timeout.
module wb_intercon_ns #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {16'h00C0, 16'h0080, 16'h0040, 16'h0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{16'hFFC0}},
  parameter int TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            wbm_address,
  input  logic [DATA_WIDTH-1:0]            wbm_writedata,
  output logic [DATA_WIDTH-1:0]            wbm_readdata,
  input  logic                             wbm_write,
  input  logic                             wbm_cycle,
  input  logic                             wbm_strobe,
  output logic                             wbm_ack,
  output logic                             wbm_err,
  output logic [ADDR_WIDTH-1:0]            wbi_address,
  output logic [DATA_WIDTH-1:0]            wbi_writedata,
  output logic                             wbi_write,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbi_readdata,
  output logic [NUM_SLAVES-1:0]            wbi_cycle,
  output logic [NUM_SLAVES-1:0]            wbi_strobe,
  input  logic [NUM_SLAVES-1:0]            wbi_ack
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  logic [1:0]            state_r, state_nx_s;
  logic [SEL_W-1:0]      sel_r, sel_nx_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
  logic [DATA_WIDTH-1:0] rdata_nx_s;
  logic                  ack_nx_s, err_nx_s;
  logic                  hit_s, match_s;
  logic [SEL_W-1:0]      hit_idx_s;
  logic [DATA_WIDTH-1:0] sel_rdata_s;
  logic                  sel_ack_s;

  assign wbi_address   = wbm_address;
  assign wbi_writedata = wbm_writedata;
  assign wbi_write     = wbm_write;

  assign sel_rdata_s = wbi_readdata[sel_r*DATA_WIDTH +: DATA_WIDTH];
  assign sel_ack_s   = wbi_ack[sel_r];

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {SEL_W{1'b0}};
    match_s   = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      match_s   = ((wbm_address & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                   (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]));
      hit_idx_s = match_s ? SEL_W'(i) : hit_idx_s;
      hit_s     = hit_s | match_s;
    end
  end

  // Transaction sequencing: next state, selection, timeout count and master responses.
  always_comb begin
    state_nx_s = state_r;
    sel_nx_s   = sel_r;
    cnt_nx_s   = cnt_r;
    rdata_nx_s = wbm_readdata;
    ack_nx_s   = 1'b0;
    err_nx_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (wbm_cycle && wbm_strobe) begin
          if (hit_s) begin
            state_nx_s = ST_ACTIVE;
            sel_nx_s   = hit_idx_s;
            cnt_nx_s   = {CNT_W{1'b0}};
          end else begin
            state_nx_s = ST_ERR;
            err_nx_s   = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // A dropped cycle abandons the transfer silently.
        if (!wbm_cycle) begin
          state_nx_s = ST_IDLE;
        end else if (sel_ack_s) begin
          state_nx_s = ST_RESP;
          ack_nx_s   = 1'b1;
          rdata_nx_s = sel_rdata_s;
        end else if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_ERR;
          err_nx_s   = 1'b1;
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RESP: state_nx_s = ST_IDLE;
      ST_ERR:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State and master-side response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      sel_r        <= {SEL_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      wbm_readdata <= {DATA_WIDTH{1'b0}};
      wbm_ack      <= 1'b0;
      wbm_err      <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      sel_r        <= sel_nx_s;
      cnt_r        <= cnt_nx_s;
      wbm_readdata <= rdata_nx_s;
      wbm_ack      <= ack_nx_s;
      wbm_err      <= err_nx_s;
    end
  end

  // Slave cycle/strobe steering: only the selected slave sees the master while active.
  always_comb begin
    wbi_cycle  = {NUM_SLAVES{1'b0}};
    wbi_strobe = {NUM_SLAVES{1'b0}};
    if (state_r == ST_ACTIVE) begin
      wbi_cycle[sel_r]  = wbm_cycle;
      wbi_strobe[sel_r] = wbm_strobe;
    end else begin
      wbi_cycle  = {NUM_SLAVES{1'b0}};
      wbi_strobe = {NUM_SLAVES{1'b0}};
    end
  end

endmodule

// File: tb/tb_wb_intercon_ns.sv
// Randomized transaction-level bench for wb_intercon_ns with a timeline model
// of each transfer and a per-cycle compare process.
module tb_wb_intercon_ns;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wbm_address, wbm_writedata, wbm_readdata;
  logic        wbm_write, wbm_cycle, wbm_strobe, wbm_ack, wbm_err;
  logic [15:0] wbi_address, wbi_writedata;
  logic        wbi_write;
  logic [63:0] wbi_readdata;
  logic [3:0]  wbi_cycle, wbi_strobe, wbi_ack;

  int checks = 0;
  int failures = 0;

  logic        check_en = 1'b0;
  logic [3:0]  exp_strobe = 4'b0000;
  logic        exp_ack = 1'b0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_rdata = 16'h0000;

  int strobe_cnt = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  logic [15:0] ack_data = 16'h0000;

  wb_intercon_ns dut (
    .clk(clk), .reset(reset),
    .wbm_address(wbm_address), .wbm_writedata(wbm_writedata), .wbm_readdata(wbm_readdata),
    .wbm_write(wbm_write), .wbm_cycle(wbm_cycle), .wbm_strobe(wbm_strobe),
    .wbm_ack(wbm_ack), .wbm_err(wbm_err),
    .wbi_address(wbi_address), .wbi_writedata(wbi_writedata), .wbi_write(wbi_write),
    .wbi_readdata(wbi_readdata), .wbi_cycle(wbi_cycle), .wbi_strobe(wbi_strobe),
    .wbi_ack(wbi_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Default map: 64-byte windows for slaves 0..3 below 0x0100, nothing else mapped.
  function automatic int model_decode(input logic [15:0] ad);
    logic [1:0] win;
    win = ad[7:6];
    if (ad < 16'h0100) return int'(win);
    return -1;
  endfunction

  // Per-cycle comparison of every DUT output against the model's expectations.
  always @(negedge clk) begin
    if (check_en) begin
      chk("wbm_ack", {63'd0, wbm_ack}, {63'd0, exp_ack});
      chk("wbm_err", {63'd0, wbm_err}, {63'd0, exp_err});
      chk("wbm_readdata", {48'd0, wbm_readdata}, {48'd0, exp_rdata});
      chk("wbi_strobe", {60'd0, wbi_strobe}, {60'd0, exp_strobe});
      chk("wbi_cycle", {60'd0, wbi_cycle}, {60'd0, exp_strobe});
      chk("wbi_address", {48'd0, wbi_address}, {48'd0, wbm_address});
      chk("wbi_writedata", {48'd0, wbi_writedata}, {48'd0, wbm_writedata});
      chk("wbi_write", {63'd0, wbi_write}, {63'd0, wbm_write});
      if (wbi_strobe != 4'b0000) strobe_cnt++;
      if (wbm_ack) begin
        ack_cnt++;
        ack_data = wbm_readdata;
      end
      if (wbm_err) err_cnt++;
    end
  end

  // d: slave ack delay in ACTIVE cycles (-1 never); a: cycle master drops wbm_cycle (0 none);
  // r: cycle reset is pulsed (0 none); spur: all non-selected acks held high.
  task automatic run_txn(input logic [15:0] addr, input logic we, input logic [15:0] wd,
                         input int d, input int a, input int r, input logic [15:0] rv,
                         input logic spur);
    int s, ack_cyc, last_strobe, resp_cyc, master_last, end_cyc;
    logic acked;
    logic [3:0] oh;
    s = model_decode(addr);
    acked = 1'b0;
    ack_cyc = -10;
    resp_cyc = -10;
    if (s < 0) begin
      last_strobe = 0; resp_cyc = 1; master_last = 1; end_cyc = 2;
    end else if (a > 0) begin
      last_strobe = a - 1; master_last = a - 1; end_cyc = a + 1;
    end else if (r > 0) begin
      last_strobe = r; master_last = r; end_cyc = r + 1;
    end else begin
      if (d >= 0 && d < TIMEOUT) begin
        acked = 1'b1; ack_cyc = d + 1; last_strobe = d + 1;
      end else begin
        last_strobe = TIMEOUT;
      end
      resp_cyc = last_strobe + 1; master_last = resp_cyc; end_cyc = resp_cyc + 1;
    end
    oh = (s >= 0) ? 4'(4'b0001 << s) : 4'b0000;
    for (int k = 0; k <= end_cyc; k++) begin
      @(posedge clk); #1;
      reset = (s >= 0 && r > 0 && k == r);
      wbm_cycle = (k <= master_last);
      wbm_strobe = (k <= master_last);
      wbm_address = (k <= master_last) ? addr : 16'($urandom);
      wbm_write = (k <= master_last) ? we : 1'($urandom);
      wbm_writedata = (k <= master_last) ? wd : 16'($urandom);
      wbi_readdata = {$urandom, $urandom};
      wbi_ack = spur ? 4'hF : 4'($urandom);
      if (s >= 0) wbi_ack[s] = (k == ack_cyc);
      if (k == ack_cyc) wbi_readdata[s*16 +: 16] = rv;
      exp_strobe = (k >= 1 && k <= last_strobe) ? oh : 4'b0000;
      exp_ack = acked && (k == resp_cyc);
      exp_err = !acked && (k == resp_cyc);
      if (acked && k == resp_cyc) exp_rdata = rv;
      if (s >= 0 && r > 0 && k == r + 1) exp_rdata = 16'h0000;
    end
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0, e0, d, a, r, m;
    logic [15:0] addr;
    reset = 1'b1;
    wbm_address = 16'h0000; wbm_writedata = 16'h0000; wbm_write = 1'b0;
    wbm_cycle = 1'b0; wbm_strobe = 1'b0;
    wbi_readdata = 64'd0; wbi_ack = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk); #1;

    // Read 0x0045, slave 1 acks immediately with BEEF.
    s0 = strobe_cnt; a0 = ack_cnt;
    run_txn(16'h0045, 1'b0, 16'h0000, 0, 0, 0, 16'hBEEF, 1'b0);
    chk("rd_0045_data", {48'd0, ack_data}, 64'h0000_0000_0000_BEEF);
    chk("rd_0045_strobes", 64'(strobe_cnt - s0), 64'd1);
    chk("rd_0045_acks", 64'(ack_cnt - a0), 64'd1);

    // Write 0x00C3 to slave 3 with three wait cycles.
    s0 = strobe_cnt; a0 = ack_cnt;
    run_txn(16'h00C3, 1'b1, 16'h1234, 3, 0, 0, 16'h5A5A, 1'b0);
    chk("wr_00c3_strobes", 64'(strobe_cnt - s0), 64'd4);
    chk("wr_00c3_acks", 64'(ack_cnt - a0), 64'd1);

    // Unmapped access.
    s0 = strobe_cnt; e0 = err_cnt;
    run_txn(16'h0100, 1'b0, 16'h0000, 0, 0, 0, 16'h0000, 1'b0);
    chk("unmapped_strobes", 64'(strobe_cnt - s0), 64'd0);
    chk("unmapped_errs", 64'(err_cnt - e0), 64'd1);

    // Slave 0 never acks: timeout.
    s0 = strobe_cnt; e0 = err_cnt; a0 = ack_cnt;
    run_txn(16'h0000, 1'b0, 16'h0000, -1, 0, 0, 16'h0000, 1'b0);
    chk("timeout_strobes", 64'(strobe_cnt - s0), 64'd16);
    chk("timeout_errs", 64'(err_cnt - e0), 64'd1);
    chk("timeout_acks", 64'(ack_cnt - a0), 64'd0);

    // Slave 2 abort in cycle 2, then reset mid-ACTIVE.
    e0 = err_cnt; a0 = ack_cnt;
    run_txn(16'h0088, 1'b0, 16'h0000, -1, 2, 0, 16'h0000, 1'b0);
    chk("abort_ack_err", 64'((ack_cnt - a0) + (err_cnt - e0)), 64'd0);
    run_txn(16'h0090, 1'b1, 16'h7777, -1, 0, 3, 16'h0000, 1'b0);
    chk("reset_rdata", {48'd0, wbm_readdata}, 64'd0);

    // Spurious acks on every other slave while slave 1 waits two cycles.
    a0 = ack_cnt; s0 = strobe_cnt;
    run_txn(16'h0050, 1'b0, 16'h0000, 2, 0, 0, 16'hC0DE, 1'b1);
    chk("spurious_strobes", 64'(strobe_cnt - s0), 64'd3);
    chk("spurious_data", {48'd0, ack_data}, 64'h0000_0000_0000_C0DE);

    for (int n = 0; n < 90; n++) begin
      addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
      a = 0; r = 0;
      m = int'($urandom_range(0, 19));
      if (m < 2) begin
        a = int'($urandom_range(1, TIMEOUT - 1)); d = -1;
      end else if (m == 2) begin
        r = int'($urandom_range(1, TIMEOUT - 1)); d = -1;
      end
      run_txn(addr, 1'($urandom), 16'($urandom), d, a, r, 16'($urandom),
              1'($urandom_range(0, 3) == 0));
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
